led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent LED outputs, 1..16.
REQ-002 SHALL have parameter PRESCALE, default 1048576: clk_osc cycles per tick, >=2.
REQ-003 SHALL have parameter PWM_W, default 8: PWM counter and duty width, 2..12.
REQ-004 SHALL have parameter BLINK_W, default 2: blink counter width in PWM periods, >=1.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1: 1 means a lit LED drives 0.
REQ-006 SHALL have port clk_osc, input, 1: sole clock, from the internal oscillator.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port wr_en, input, 1: configuration write strobe.
REQ-009 SHALL have port wr_ch, input, 4: target channel index.
REQ-010 SHALL have port wr_mode, input, 3: mode code.
REQ-011 SHALL have port wr_duty, input, PWM_W: duty value.
REQ-012 SHALL have port led, output, CHANNELS: registered LED drive.
REQ-013 SHALL have port tick, output, 1: registered one-cycle prescaler pulse.
REQ-014 SHALL have port period_end, output, 1: registered one-cycle PWM-wrap pulse.

Function
REQ-015 SHALL count presc from 0 to PRESCALE-1, then wrap to 0; tick_int = (presc == PRESCALE-1).
REQ-016 SHALL increment pwm_cnt (PWM_W bits) when tick_int is 1, wrapping from 2^PWM_W-1 to 0.
REQ-017 SHALL assert pe_int = tick_int AND pwm_cnt == 2^PWM_W-1.
REQ-018 SHALL increment blink_cnt (BLINK_W bits, wrapping) when pe_int is 1; blink phase = MSB of blink_cnt.
REQ-019 SHALL hold per-channel registers: mode (3b), duty (PWM_W), level (PWM_W) and dir (0 = up).
REQ-020 SHALL, at each edge where wr_en=1 and wr_ch<CHANNELS, load mode<=wr_mode and duty<=wr_duty for that channel, and set level<=0 and dir<=0.
REQ-021 SHALL ignore a write with wr_ch>=CHANNELS; no state changes.
REQ-022 SHALL decode mode 0 as OFF: lit=0.
REQ-023 SHALL decode mode 1 as ON: lit=1.
REQ-024 SHALL decode mode 2 as BLINK: lit = blink phase.
REQ-025 SHALL decode mode 3 as PWM: lit = (pwm_cnt < duty).
REQ-026 SHALL decode mode 4 as BREATHE: lit = (pwm_cnt < level).
REQ-027 SHALL decode modes 5-7 as OFF.
REQ-028 SHALL, in BREATHE mode when pe_int=1: if dir=0, level<=level+1, and dir<=1 when the new level = 2^PWM_W-1; if dir=1, level<=level-1, and dir<=0 when the new level = 0.
REQ-029 SHALL give a write priority over a breathe update when both hit the same channel in the same cycle.
REQ-030 SHALL register led[i] <= lit[i] XOR ACTIVE_LOW, one cycle after the state it reflects.
REQ-031 SHALL make a new mode visible on led at the second edge after wr_en is sampled.
REQ-032 SHALL register tick and period_end from tick_int and pe_int, one cycle late.
REQ-033 SHALL give duty=0 a constant unlit output and duty=2^PWM_W-1 an output lit for 2^PWM_W-1 of 2^PWM_W ticks.

Reset
REQ-034 SHALL, while reset=0, asynchronously force presc, pwm_cnt, blink_cnt, all mode/duty/level/dir, tick and period_end to 0.
REQ-035 SHALL, while reset=0, force led to all-ones if ACTIVE_LOW=1, else all-zeros.
REQ-036 SHALL apply reset mid-pattern with the same immediate effect and no partial update.
REQ-037 SHALL resume counting from 0 on the first clk_osc edge after reset returns to 1.

Verification (CHANNELS=2, PRESCALE=4, PWM_W=4, BLINK_W=2, ACTIVE_LOW=1)
REQ-038 SHALL cover reset: pulse reset=0 during PWM activity -> led=2'b11, tick=0, period_end=0 immediately; after release, first tick 4 cycles later.
REQ-039 SHALL cover ON: write ch0 mode=1 -> led[0]=0 from the second edge onward, led[1]=1.
REQ-040 SHALL cover PWM: write ch1 mode=3 duty=4 -> led[1]=0 for 16 of every 64 cycles; period_end every 64 cycles.
REQ-041 SHALL cover BLINK: write ch0 mode=2 -> led[0] toggles every 128 cycles.
REQ-042 SHALL cover BREATHE: write ch0 mode=4 -> level hits 15 after 15 period_ends, returns to 0 after 30; led[0] lit-time tracks level.
REQ-043 SHALL cover bad writes: wr_ch=2 with mode 1 -> no change; duty=0 -> never lit; write coinciding with pe_int -> write values win.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: a shared prescaler/PWM/blink timebase feeds per-channel
// OFF/ON/BLINK/PWM/BREATHE pattern decoders with registered, polarity-adjusted outputs.
module led_pattern_gen #(
  parameter int CHANNELS   = 2,
  parameter int PRESCALE   = 1048576,
  parameter int PWM_W      = 8,
  parameter int BLINK_W    = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk_osc,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [2:0]          wr_mode,
  input  logic [PWM_W-1:0]    wr_duty,
  output logic [CHANNELS-1:0] led,
  output logic                tick,
  output logic                period_end
);

  localparam int                 PRESC_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PWM_W-1:0]   PWM_MAX    = '1;
  localparam logic [PWM_W-1:0]   PWM_ONE    = PWM_W'(1);
  localparam logic               POLARITY   = (ACTIVE_LOW != 0);

  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_PWM     = 3'd3;
  localparam logic [2:0] MODE_BREATHE = 3'd4;

  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               tick_int;
  logic               pe_int;

  logic [2:0]         mode  [CHANNELS];
  logic [PWM_W-1:0]   duty  [CHANNELS];
  logic [PWM_W-1:0]   level [CHANNELS];
  logic               dir   [CHANNELS];
  logic [CHANNELS-1:0] lit;

  assign tick_int = (presc == PRESC_LAST);
  assign pe_int   = tick_int && (pwm_cnt == PWM_MAX);

  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      blink_cnt  <= '0;
      tick       <= 1'b0;
      period_end <= 1'b0;
    end else begin
      presc      <= tick_int ? '0 : presc + 1'b1;
      tick       <= tick_int;
      period_end <= pe_int;
      if (tick_int)
        pwm_cnt <= pwm_cnt + 1'b1;
      if (pe_int)
        blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // A configuration write restarts the breathe ramp and overrides any same-cycle ramp step.
  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]  <= '0;
        duty[i]  <= '0;
        level[i] <= '0;
        dir[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_ch == 4'(i))) begin
          mode[i]  <= wr_mode;
          duty[i]  <= wr_duty;
          level[i] <= '0;
          dir[i]   <= 1'b0;
        end else if ((mode[i] == MODE_BREATHE) && pe_int) begin
          if (!dir[i]) begin
            level[i] <= level[i] + 1'b1;
            if (level[i] == PWM_MAX - 1'b1)
              dir[i] <= 1'b1;
          end else begin
            level[i] <= level[i] - 1'b1;
            if (level[i] == PWM_ONE)
              dir[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode[i])
        MODE_ON:      lit[i] = 1'b1;
        MODE_BLINK:   lit[i] = blink_cnt[BLINK_W-1];
        MODE_PWM:     lit[i] = (pwm_cnt < duty[i]);
        MODE_BREATHE: lit[i] = (pwm_cnt < level[i]);
        default:      lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset)
      led <= {CHANNELS{POLARITY}};
    else
      led <= lit ^ {CHANNELS{POLARITY}};
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: an edge-count reference model queues the expected
// outputs of every clock edge and a separate monitor compares them against the DUT.
module tb_led_pattern_gen;

  localparam int CH     = 2;
  localparam int PS     = 4;
  localparam int PW     = 4;
  localparam int BW     = 2;
  localparam int PERIOD = PS * (1 << PW);

  logic          clk_osc = 1'b0;
  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [3:0]    wr_ch   = '0;
  logic [2:0]    wr_mode = '0;
  logic [PW-1:0] wr_duty = '0;
  logic [CH-1:0] led;
  logic          tick;
  logic          period_end;

  led_pattern_gen #(
    .CHANNELS(CH), .PRESCALE(PS), .PWM_W(PW), .BLINK_W(BW), .ACTIVE_LOW(1)
  ) dut (
    .clk_osc(clk_osc), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_duty(wr_duty), .led(led), .tick(tick), .period_end(period_end)
  );

  always #5 clk_osc = ~clk_osc;

  typedef struct {
    logic [2:0] mode;
    int         duty;
    int         wedge;
  } cfg_t;

  typedef struct packed {
    logic [CH-1:0] led;
    logic          tick;
    logic          pe;
  } exp_t;

  cfg_t cfg [CH];
  exp_t exp_q [$];
  int   n;
  int   checks = 0;
  int   errors = 0;

  // Breathe brightness after k ramp steps: a 0..15..0 triangle repeating every 30 steps.
  function automatic int tri_level(int k);
    int m;
    m = k % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  function automatic logic model_lit(int c, int edges);
    int pwm;
    int blink;
    pwm   = (edges / PS) % (1 << PW);
    blink = (edges / PERIOD) % (1 << BW);
    case (cfg[c].mode)
      3'd1:    return 1'b1;
      3'd2:    return blink >= (1 << (BW - 1));
      3'd3:    return pwm < cfg[c].duty;
      3'd4:    return pwm < tri_level(edges / PERIOD - cfg[c].wedge / PERIOD);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    if (!reset) begin
      e = '{led: '1, tick: 1'b0, pe: 1'b0};
      n = 0;
      for (int c = 0; c < CH; c++) cfg[c] = '{mode: 3'd0, duty: 0, wedge: 0};
    end else begin
      for (int c = 0; c < CH; c++) e.led[c] = ~model_lit(c, n);
      e.tick = (n % PS == PS - 1);
      e.pe   = (n % PERIOD == PERIOD - 1);
      n++;
      if (wr_en && (wr_ch < CH))
        cfg[wr_ch] = '{mode: wr_mode, duty: int'(wr_duty), wedge: n};
    end
    exp_q.push_back(e);
  endtask

  task automatic check_output(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) cfg[c] = '{mode: 3'd0, duty: 0, wedge: 0};
    n = 0;
    forever begin
      @(posedge clk_osc);
      model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_osc);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("led", 4'(led), 4'(e.led));
        check_output("tick", 4'(tick), 4'(e.tick));
        check_output("period_end", 4'(period_end), 4'(e.pe));
      end
    end
  end

  task automatic idle(int cycles);
    repeat (cycles) @(negedge clk_osc);
  endtask

  task automatic apply_stimulus(int ch, int mode, int duty);
    @(negedge clk_osc);
    wr_en   = 1'b1;
    wr_ch   = 4'(ch);
    wr_mode = 3'(mode);
    wr_duty = PW'(duty);
    @(negedge clk_osc);
    wr_en   = 1'b0;
  endtask

  task automatic write_on_period_end(int ch, int mode, int duty);
    bit found;
    found = 1'b0;
    for (int i = 0; i < PERIOD + 4 && !found; i++) begin
      @(negedge clk_osc);
      if (n % PERIOD == PERIOD - 1) found = 1'b1;
    end
    if (!found) begin
      errors++;
      $display("[TB] FAIL pe_align: got no period boundary expected one within %0d cycles", PERIOD + 4);
    end
    wr_en   = 1'b1;
    wr_ch   = 4'(ch);
    wr_mode = 3'(mode);
    wr_duty = PW'(duty);
    @(negedge clk_osc);
    wr_en   = 1'b0;
  endtask

  task automatic reset_mid_pattern();
    bit found;
    found = 1'b0;
    for (int i = 0; i < PERIOD + 4 && !found; i++) begin
      @(posedge clk_osc);
      #3;
      if (n % PERIOD == 0) found = 1'b1;
    end
    reset = 1'b0;
    #1;
    check_output("async_led", 4'(led), 4'b0011);
    check_output("async_tick", 4'(tick), 4'b0000);
    check_output("async_period_end", 4'(period_end), 4'b0000);
    repeat (2) @(negedge clk_osc);
    reset = 1'b1;
  endtask

  initial begin
    idle(3);
    reset = 1'b1;
    idle(6);

    apply_stimulus(0, 1, 0);
    idle(20);
    apply_stimulus(1, 3, 4);
    idle(140);
    apply_stimulus(0, 2, 0);
    idle(300);
    apply_stimulus(0, 4, 0);
    idle(32 * PERIOD);

    apply_stimulus(2, 1, 7);
    apply_stimulus(9, 1, 3);
    idle(20);
    apply_stimulus(1, 3, 0);
    idle(PERIOD + 10);
    apply_stimulus(1, 3, 15);
    idle(PERIOD + 10);

    apply_stimulus(0, 4, 0);
    idle(3 * PERIOD + 5);
    write_on_period_end(0, 4, 0);
    idle(3 * PERIOD);
    write_on_period_end(1, 3, 9);
    idle(PERIOD);

    reset_mid_pattern();
    idle(20);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_osc);
      wr_en   = ($urandom_range(0, 15) == 0);
      wr_ch   = 4'($urandom_range(0, 3));
      wr_mode = 3'($urandom_range(0, 7));
      wr_duty = PW'($urandom_range(0, (1 << PW) - 1));
    end
    wr_en = 1'b0;
    idle(50);
    reset_mid_pattern();
    idle(2 * PERIOD);

    @(posedge clk_osc);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
